// File: rtl/fft_pkg.sv
// Frame constants and stream-state encoding shared by the UART front end and the FFT core.
package fft_pkg;
    localparam int N_SAMPLES = 16;
    localparam int SAMPLE_W  = 16;
    localparam int IDX_W     = $clog2(N_SAMPLES);

    typedef enum logic {
        COLLECT,
        STREAM
    } state_t;
endpackage

// File: rtl/uart_byte_event.sv
// Turns the falling edge of the UART receive-state into good-byte / bad-byte strobes.
module uart_byte_event (
    input  logic clk,
    input  logic rst,
    input  logic rx_busy,
    input  logic rx_error,
    output logic byte_evt,
    output logic err_evt
);
    logic busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= 1'b0;
        else     busy_q <= rx_busy;
    end

    assign byte_evt = busy_q & ~rx_busy & ~rx_error;
    assign err_evt  = busy_q & ~rx_busy &  rx_error;
endmodule

// File: rtl/uart_sample_assembler.sv
// Packs UART bytes little-endian into samples, buffers one frame, then streams it to the FFT.
module uart_sample_assembler #(
    parameter int N_SAMPLES      = fft_pkg::N_SAMPLES,
    parameter int SAMPLE_W       = fft_pkg::SAMPLE_W,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [7:0]                   i_rx_byte,
    input  logic                         i_rx_busy,
    input  logic                         i_rx_error,
    input  logic                         i_fft_ready,
    output logic [SAMPLE_W-1:0]          o_sample,
    output logic                         o_sample_valid,
    output logic [$clog2(N_SAMPLES)-1:0] o_sample_idx,
    output logic                         o_last,
    output logic                         o_collecting,
    output logic                         o_frame_drop,
    output logic                         o_overrun
);
    import fft_pkg::state_t;
    import fft_pkg::COLLECT;
    import fft_pkg::STREAM;

    localparam int IDX_W = $clog2(N_SAMPLES);
    localparam int BYTES = SAMPLE_W / 8;
    localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [BC_W-1:0]  LAST_LANE = BC_W'(BYTES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_SAMPLES - 1);
    localparam logic [TO_W-1:0]  TO_LIMIT  = TO_W'(TIMEOUT_CYCLES - 1);

    logic                byte_evt, err_evt;
    state_t              state, state_n;
    logic [BC_W-1:0]     byte_cnt, byte_cnt_n;
    logic [IDX_W-1:0]    smp_cnt, smp_cnt_n;
    logic [IDX_W-1:0]    rd_idx, rd_idx_n;
    logic [TO_W-1:0]     to_cnt, to_cnt_n;
    logic [SAMPLE_W-1:0] asm_q, asm_n;
    logic                commit, drop_n, ovr_n, partial;
    logic [SAMPLE_W-1:0] buffer [N_SAMPLES];

    uart_byte_event u_byte_event (
        .clk      (i_clk),
        .rst      (i_rst),
        .rx_busy  (i_rx_busy),
        .rx_error (i_rx_error),
        .byte_evt (byte_evt),
        .err_evt  (err_evt)
    );

    assign partial = (byte_cnt != '0) || (smp_cnt != '0);

    always_comb begin
        state_n    = state;
        byte_cnt_n = byte_cnt;
        smp_cnt_n  = smp_cnt;
        rd_idx_n   = rd_idx;
        to_cnt_n   = to_cnt;
        asm_n      = asm_q;
        commit     = 1'b0;
        drop_n     = 1'b0;
        ovr_n      = 1'b0;
        case (state)
            COLLECT: begin
                // A byte always beats a coincident timeout: it clears the idle counter first.
                if (byte_evt) begin
                    asm_n[8*int'(byte_cnt) +: 8] = i_rx_byte;
                    to_cnt_n = '0;
                    if (byte_cnt == LAST_LANE) begin
                        byte_cnt_n = '0;
                        commit     = 1'b1;
                        smp_cnt_n  = smp_cnt + 1'b1;
                        if (smp_cnt == LAST_IDX) state_n = STREAM;
                    end else begin
                        byte_cnt_n = byte_cnt + 1'b1;
                    end
                end else if (err_evt) begin
                    byte_cnt_n = '0;
                    smp_cnt_n  = '0;
                    to_cnt_n   = '0;
                    drop_n     = partial;
                end else if (partial) begin
                    if (to_cnt == TO_LIMIT) begin
                        byte_cnt_n = '0;
                        smp_cnt_n  = '0;
                        to_cnt_n   = '0;
                        drop_n     = 1'b1;
                    end else begin
                        to_cnt_n = to_cnt + 1'b1;
                    end
                end else begin
                    to_cnt_n = '0;
                end
            end
            STREAM: begin
                to_cnt_n = '0;
                ovr_n    = byte_evt;
                if (i_fft_ready) begin
                    rd_idx_n = rd_idx + 1'b1;
                    if (rd_idx == LAST_IDX) state_n = COLLECT;
                end
            end
            default: state_n = COLLECT;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= COLLECT;
            byte_cnt     <= '0;
            smp_cnt      <= '0;
            rd_idx       <= '0;
            to_cnt       <= '0;
            asm_q        <= '0;
            o_frame_drop <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            state        <= state_n;
            byte_cnt     <= byte_cnt_n;
            smp_cnt      <= smp_cnt_n;
            rd_idx       <= rd_idx_n;
            to_cnt       <= to_cnt_n;
            asm_q        <= asm_n;
            o_frame_drop <= drop_n;
            o_overrun    <= ovr_n;
        end
    end

    always_ff @(posedge i_clk) begin
        if (commit) buffer[smp_cnt] <= asm_n;
    end

    assign o_sample_valid = (state == STREAM);
    assign o_collecting   = (state == COLLECT);
    assign o_sample_idx   = rd_idx;
    assign o_last         = o_sample_valid && (rd_idx == LAST_IDX);
    assign o_sample       = o_sample_valid ? buffer[rd_idx] : '0;
endmodule

// File: tb/tb_uart_sample_assembler.sv
// Directed checks of byte packing, streaming handshake, timeout, error, overrun and reset.
module tb_uart_sample_assembler;
    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [7:0]  i_rx_byte;
    logic        i_rx_busy;
    logic        i_rx_error;
    logic        i_fft_ready;
    logic [15:0] o_sample;
    logic        o_sample_valid;
    logic [3:0]  o_sample_idx;
    logic        o_last;
    logic        o_collecting;
    logic        o_frame_drop;
    logic        o_overrun;

    int passed = 0;
    int total  = 0;
    int drop_cnt = 0;
    int ovr_cnt  = 0;
    int d0, o0;
    logic [15:0] exp_s [16];

    uart_sample_assembler #(
        .N_SAMPLES      (16),
        .SAMPLE_W       (16),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_rx_byte      (i_rx_byte),
        .i_rx_busy      (i_rx_busy),
        .i_rx_error     (i_rx_error),
        .i_fft_ready    (i_fft_ready),
        .o_sample       (o_sample),
        .o_sample_valid (o_sample_valid),
        .o_sample_idx   (o_sample_idx),
        .o_last         (o_last),
        .o_collecting   (o_collecting),
        .o_frame_drop   (o_frame_drop),
        .o_overrun      (o_overrun)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        drop_cnt <= drop_cnt + int'(o_frame_drop);
        ovr_cnt  <= ovr_cnt + int'(o_overrun);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Busy high for one cycle, then low with the byte held: the event falls in the cycle after.
    task automatic send_byte(input logic [7:0] b, input logic err);
        @(posedge i_clk); #1;
        i_rx_busy = 1'b1; i_rx_byte = b; i_rx_error = err;
        @(posedge i_clk); #1;
        i_rx_busy = 1'b0;
    endtask

    task automatic send_frame();
        for (int i = 0; i < 16; i++) begin
            send_byte(exp_s[i][7:0], 1'b0);
            send_byte(exp_s[i][15:8], 1'b0);
        end
    endtask

    task automatic check_stream(input string tag);
        @(negedge i_clk);
        chk({tag, "_pre_valid"}, 32'(o_sample_valid), 32'd0);
        for (int i = 0; i < 16; i++) begin
            @(negedge i_clk);
            chk({tag, "_valid"}, 32'(o_sample_valid), 32'd1);
            chk({tag, "_idx"}, 32'(o_sample_idx), 32'(i));
            chk({tag, "_sample"}, 32'(o_sample), 32'(exp_s[i]));
            chk({tag, "_last"}, 32'(o_last), (i == 15) ? 32'd1 : 32'd0);
        end
        @(negedge i_clk);
        chk({tag, "_post_valid"}, 32'(o_sample_valid), 32'd0);
        chk({tag, "_post_collect"}, 32'(o_collecting), 32'd1);
    endtask

    initial begin
        i_rst = 1'b1; i_rx_byte = '0; i_rx_busy = 1'b0; i_rx_error = 1'b0; i_fft_ready = 1'b1;
        #1;
        chk("rst_valid", 32'(o_sample_valid), 32'd0);
        chk("rst_last", 32'(o_last), 32'd0);
        chk("rst_drop", 32'(o_frame_drop), 32'd0);
        chk("rst_ovr", 32'(o_overrun), 32'd0);
        chk("rst_idx", 32'(o_sample_idx), 32'd0);
        chk("rst_collect", 32'(o_collecting), 32'd1);
        chk("rst_sample", 32'(o_sample), 32'd0);
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;

        // Frame of 0x0001..0x0010 with the FFT always ready
        for (int i = 0; i < 16; i++) exp_s[i] = 16'(i + 1);
        send_frame();
        check_stream("ramp");

        // Same frame, ready low on even stream cycles and high on odd ones
        send_frame();
        @(negedge i_clk);
        chk("tog_pre_valid", 32'(o_sample_valid), 32'd0);
        for (int c = 0; c < 32; c++) begin
            @(posedge i_clk); #1;
            i_fft_ready = (c % 2 == 1);
            @(negedge i_clk);
            chk("tog_valid", 32'(o_sample_valid), 32'd1);
            chk("tog_idx", 32'(o_sample_idx), 32'(c / 2));
            chk("tog_sample", 32'(o_sample), 32'(exp_s[c / 2]));
        end
        @(posedge i_clk); #1;
        i_fft_ready = 1'b1;
        @(negedge i_clk);
        chk("tog_post_valid", 32'(o_sample_valid), 32'd0);

        // Partial frame of 5 bytes, then idle past the timeout
        d0 = drop_cnt;
        for (int i = 0; i < 5; i++) send_byte(8'(8'h30 + i), 1'b0);
        repeat (80) @(negedge i_clk);
        chk("to_drop_count", 32'(drop_cnt - d0), 32'd1);
        chk("to_collect", 32'(o_collecting), 32'd1);
        for (int i = 0; i < 16; i++) exp_s[i] = 16'h55AA;
        send_frame();
        check_stream("after_to");

        // Three good bytes then a bad one; the next frame must realign to lane 0
        d0 = drop_cnt;
        for (int i = 0; i < 3; i++) send_byte(8'(8'h70 + i), 1'b0);
        send_byte(8'hFF, 1'b1);
        repeat (5) @(negedge i_clk);
        chk("err_drop_count", 32'(drop_cnt - d0), 32'd1);
        for (int i = 0; i < 16; i++) exp_s[i] = 16'(16'hC010 + i);
        send_frame();
        check_stream("after_err");

        // Bytes arriving while the FFT stalls are dropped with an overrun pulse each
        i_fft_ready = 1'b0;
        for (int i = 0; i < 16; i++) exp_s[i] = 16'(16'h8000 + 3 * i);
        send_frame();
        repeat (2) @(negedge i_clk);
        chk("ovr_hold_valid", 32'(o_sample_valid), 32'd1);
        o0 = ovr_cnt;
        send_byte(8'hEE, 1'b0);
        send_byte(8'hDD, 1'b0);
        repeat (3) @(negedge i_clk);
        chk("ovr_count", 32'(ovr_cnt - o0), 32'd2);
        chk("ovr_hold_idx", 32'(o_sample_idx), 32'd0);
        chk("ovr_hold_sample", 32'(o_sample), 32'(exp_s[0]));
        @(posedge i_clk); #1;
        i_fft_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge i_clk);
            chk("ovr_idx", 32'(o_sample_idx), 32'(i));
            chk("ovr_sample", 32'(o_sample), 32'(exp_s[i]));
        end
        @(negedge i_clk);
        chk("ovr_post_valid", 32'(o_sample_valid), 32'd0);

        // Asynchronous reset while sample 7 is on the output
        for (int i = 0; i < 16; i++) exp_s[i] = 16'(16'h1200 + i);
        send_frame();
        @(negedge i_clk);
        repeat (8) @(negedge i_clk);
        chk("rst7_idx", 32'(o_sample_idx), 32'd7);
        d0 = drop_cnt;
        #1 i_rst = 1'b1;
        #1;
        chk("rst7_valid", 32'(o_sample_valid), 32'd0);
        chk("rst7_idx0", 32'(o_sample_idx), 32'd0);
        chk("rst7_collect", 32'(o_collecting), 32'd1);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        for (int i = 0; i < 16; i++) exp_s[i] = 16'(16'hA5F0 + i);
        send_frame();
        check_stream("after_rst");
        chk("rst7_no_drop", 32'(drop_cnt - d0), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/uart_sample_assembler.md
Name: uart_sample_assembler

Overview:
Sits directly downstream of UART_RX and upstream of the 16-point FFT core. It detects each completed byte from UART_RX's receive-state and error outputs. Received bytes are packed little-endian into SAMPLE_W-bit samples, and N_SAMPLES samples are collected into a frame buffer. The full frame is then streamed to the FFT with a valid/ready handshake.

Parameters:
N_SAMPLES, 16, samples per frame (power of 2)
SAMPLE_W, 16, sample width in bits (multiple of 8; SAMPLE_W/8 bytes per sample)
TIMEOUT_CYCLES, 100000, idle cycles after the last accepted byte before a partial frame is discarded

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous, active-high reset
i_rx_byte  in  8  UART_RX o_Received_byte
i_rx_busy  in  1  UART_RX o_receive_state (high while a byte is being received)
i_rx_error  in  1  UART_RX o_error (valid when i_rx_busy falls)
i_fft_ready  in  1  FFT accepts a sample this cycle
o_sample  out  SAMPLE_W  current output sample
o_sample_valid  out  1  o_sample/o_sample_idx valid
o_sample_idx  out  clog2(N_SAMPLES)  index of o_sample within frame
o_last  out  1  high with o_sample_valid on index N_SAMPLES-1
o_collecting  out  1  high in COLLECT state
o_frame_drop  out  1  one-cycle pulse when a partial frame is discarded
o_overrun  out  1  one-cycle pulse when a byte arrives during STREAM and is dropped

Behaviour:
- Reset (async, i_rst=1):
  - state=COLLECT; all counters 0; busy_q=0.
  - Outputs: o_sample_valid=0, o_last=0, o_frame_drop=0, o_overrun=0, o_sample_idx=0, o_collecting=1, o_sample=0.
  - Buffer contents are don't-care.
  - Reset mid-frame or mid-stream aborts everything; no pulses are emitted.
- Byte event: busy_q is i_rx_busy registered.
  - byte_evt = busy_q & ~i_rx_busy & ~i_rx_error. i_rx_byte is sampled in that same cycle.
  - err_evt = busy_q & ~i_rx_busy & i_rx_error.
- COLLECT:
  - byte_evt writes the byte into lane byte_cnt of the sample currently being assembled; lane 0 is bits [7:0].
  - The byte in the last lane commits the sample to buffer[smp_cnt] and increments smp_cnt. byte_cnt wraps to 0.
  - Commit of sample N_SAMPLES-1 -> STREAM on the next edge. In that first STREAM cycle: o_sample_valid=1, o_sample_idx=0, o_sample=buffer[0]. Latency is 1 cycle from the final byte_evt.
  - Timeout counter:
    - Clears on every byte_evt.
    - Counts only while byte_cnt!=0 or smp_cnt!=0.
    - On reaching TIMEOUT_CYCLES-1: clear byte_cnt and smp_cnt, pulse o_frame_drop.
  - err_evt: clear byte_cnt and smp_cnt. Pulse o_frame_drop only if partial data existed; otherwise no pulse.
  - Timeout and byte_evt in the same cycle: byte_evt wins; the counter clears and the byte is accepted.
- STREAM:
  - o_sample = buffer[rd_idx], held stable while o_sample_valid & ~i_fft_ready.
  - Transfer occurs on o_sample_valid & i_fft_ready; rd_idx increments.
  - o_last = o_sample_valid & (rd_idx==N_SAMPLES-1).
  - Transfer of the last sample -> COLLECT next edge, with o_sample_valid=0 and counters 0.
  - byte_evt during STREAM: the byte is dropped and o_overrun pulses.
  - err_evt during STREAM is ignored.
  - The timeout counter is held at 0.
- Width rules: byte_cnt is clog2(SAMPLE_W/8) bits (1 bit minimum); smp_cnt/rd_idx are clog2(N_SAMPLES) bits. All counters wrap naturally at the end of a frame.

Decomposition:
- Shared package (fft_pkg):
  - N_SAMPLES, SAMPLE_W, IDX_W constants.
  - State enum {COLLECT, STREAM}, so the FFT core and UART stages share frame constants.
- One sub-module, uart_byte_event: registers i_rx_busy and produces byte_evt/err_evt.
- Frame buffer and FSM stay in the top level.

Test Plan:
- Send 32 bytes 0x01,0x00,0x02,0x00,…,0x10,0x00 with i_fft_ready=1 -> 16 consecutive valid cycles, samples 0x0001..0x0010, idx 0..15, o_last only on 0x0010; the first valid occurs 1 cycle after the last byte_evt.
- Same frame with i_fft_ready toggling 1/0 every cycle -> every sample presented exactly once, o_sample stable during ready=0, 32 cycles total.
- Send 5 bytes, then idle TIMEOUT_CYCLES (reduced to 50 in the bench) -> o_frame_drop one pulse, o_collecting=1. A following full frame of 0xAA,0x55 pairs -> 16 samples of 0x55AA.
- Send 3 bytes, then one byte with i_rx_error=1 -> o_frame_drop pulse. The next 32 good bytes form a complete, correctly aligned frame.
- Complete a frame, hold i_fft_ready=0, inject 2 byte_evts -> 2 o_overrun pulses, buffer content unchanged on release.
- Assert i_rst for one cycle mid-STREAM at idx 7 -> o_sample_valid drops immediately (async). The next frame starts at idx 0 with no o_frame_drop.
